// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter between VGA display fetch and two pixel writers
//
// Ports:
//   clk, clr_n            pixel clock, synchronous active-low reset
//   hc, vc, vidon         timing generator counters and visible-window flag
//   hsync_in, vsync_in    syncs from the timing generator
//   wN_req/addr/data      writer N request (held until wN_gnt), N = 0,1
//   wN_gnt                one-cycle pulse when writer N's request is consumed
//   ram_en/we/addr/wdata  registered strobes to the single-port sync RAM
//   ram_rdata             RAM read data, valid one cycle after ram_en
//   pix_rgb, pix_valid    pixel colour to the DAC and its visible flag
//   hsync_out, vsync_out  syncs delayed to line up with pix_rgb
module vga_fb_arbiter #(
    parameter int HBP     = 144,
    parameter int VBP     = 31,
    parameter int FB_W    = 320,
    parameter int FB_H    = 240,
    parameter int COLOR_W = 12,
    parameter int ADDR_W  = 17
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [9:0]         hc,
    input  logic [9:0]         vc,
    input  logic               vidon,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               w0_req,
    input  logic [ADDR_W-1:0]  w0_addr,
    input  logic [COLOR_W-1:0] w0_data,
    output logic               w0_gnt,
    input  logic               w1_req,
    input  logic [ADDR_W-1:0]  w1_addr,
    input  logic [COLOR_W-1:0] w1_data,
    output logic               w1_gnt,
    output logic               ram_en,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [COLOR_W-1:0] ram_wdata,
    input  logic [COLOR_W-1:0] ram_rdata,
    output logic [COLOR_W-1:0] pix_rgb,
    output logic               pix_valid,
    output logic               hsync_out,
    output logic               vsync_out
);

    localparam int FB_SIZE = FB_W * FB_H;

    // rr = 0: writer 0 wins a tie; rr = 1: writer 1 wins a tie
    logic               rr, rr_n;
    logic [9:0]         col, row;
    logic [ADDR_W-1:0]  disp_addr;
    logic               elig0, elig1, pick0, pick1;
    logic               en_n, we_n, gnt0_n, gnt1_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [COLOR_W-1:0] wdata_n;
    logic [1:0]         vid_d, hs_d, vs_d;

    always_comb begin
        // Each stored pixel covers a 2x2 block on screen, so drop the LSB of both offsets.
        col = (hc - 10'(HBP)) >> 1;
        row = (vc - 10'(VBP)) >> 1;
        // row * 320 as (row << 8) + (row << 6)
        disp_addr = (ADDR_W'(row) << 8) + (ADDR_W'(row) << 6) + ADDR_W'(col);

        // A writer whose grant is showing this cycle has already been consumed;
        // its req is stale until it reacts, so it must not be granted again.
        elig0 = w0_req & ~w0_gnt;
        elig1 = w1_req & ~w1_gnt;
        pick0 = elig0 & (~elig1 | ~rr);
        pick1 = elig1 & (~elig0 | rr);

        en_n    = 1'b0;
        we_n    = 1'b0;
        addr_n  = '0;
        wdata_n = '0;
        gnt0_n  = 1'b0;
        gnt1_n  = 1'b0;
        rr_n    = rr;

        if (vidon) begin
            en_n   = 1'b1;
            addr_n = disp_addr;
        end else if (pick0) begin
            gnt0_n = 1'b1;
            rr_n   = 1'b1;
            // Out-of-range writes are acknowledged but never reach the RAM.
            if (w0_addr < ADDR_W'(FB_SIZE)) begin
                en_n    = 1'b1;
                we_n    = 1'b1;
                addr_n  = w0_addr;
                wdata_n = w0_data;
            end
        end else if (pick1) begin
            gnt1_n = 1'b1;
            rr_n   = 1'b0;
            if (w1_addr < ADDR_W'(FB_SIZE)) begin
                en_n    = 1'b1;
                we_n    = 1'b1;
                addr_n  = w1_addr;
                wdata_n = w1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rr        <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            w0_gnt    <= 1'b0;
            w1_gnt    <= 1'b0;
            vid_d     <= '0;
            hs_d      <= '0;
            vs_d      <= '0;
        end else begin
            rr        <= rr_n;
            ram_en    <= en_n;
            ram_we    <= we_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            w0_gnt    <= gnt0_n;
            w1_gnt    <= gnt1_n;
            // Two stages: one for the registered RAM strobe, one for the RAM read.
            vid_d     <= {vid_d[0], vidon};
            hs_d      <= {hs_d[0], hsync_in};
            vs_d      <= {vs_d[0], vsync_in};
        end
    end

    assign pix_valid = vid_d[1];
    assign hsync_out = hs_d[1];
    assign vsync_out = vs_d[1];
    assign pix_rgb   = pix_valid ? ram_rdata : '0;

endmodule
